// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Instruction memory filled by a byte-serial valid/ready stream and read by
//   the fetch stage. Bytes are packed MSB-first into words; the write address
//   auto-increments. A load finishes on END_WORD (which is itself stored) or
//   when the memory fills up, in which case o_load_err is raised.
//   Fetch is registered, stall-aware, and flags out-of-range PCs.
//
// Ports
//   i_clk_write   single clock for all logic
//   i_rst         asynchronous active-high reset
//   i_load_start  one-cycle pulse, (re)starts a load; wins over everything else
//   i_byte_valid  stream byte valid
//   i_byte        stream byte
//   o_byte_ready  loader accepts a byte (state LOAD)
//   i_stall       hold fetch outputs
//   i_pc          byte address to fetch
//   o_instruction registered fetched word (0 on fault)
//   o_pc          registered PC matching o_instruction
//   o_pc_fault    registered, PC word index >= DEPTH
//   o_loading     state is LOAD
//   o_load_done   state is RUN
//   o_load_err    sticky, memory filled without END_WORD
//   o_prog_len    words written by the last load
module imem_stream_loader #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           DEPTH          = 64,
    parameter int unsigned           ADDR_WIDTH     = $clog2(DEPTH),
    parameter int unsigned           BYTES_PER_WORD = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] END_WORD       = 32'hFFFF_FFFF
) (
    input  logic                  i_clk_write,
    input  logic                  i_rst,
    input  logic                  i_load_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    input  logic                  i_stall,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_pc_fault,
    output logic                  o_loading,
    output logic                  o_load_done,
    output logic                  o_load_err,
    output logic [ADDR_WIDTH:0]   o_prog_len
);

    localparam int unsigned CNT_W      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned BYTE_SHIFT = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0]     prog_len_q, prog_len_d;
    logic                    load_err_q, load_err_d;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [CNT_W-1:0]        lane;

    logic [DATA_WIDTH-1:0]   instr_q, pc_q;
    logic                    fault_q;
    logic [DATA_WIDTH-1:0]   word_idx;
    logic                    pc_in_range;
    logic [ADDR_WIDTH-1:0]   rd_idx;

    // ---------------------------------------------------------------------
    // Load FSM and byte assembly
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        wr_addr_d  = wr_addr_q;
        prog_len_d = prog_len_q;
        load_err_d = load_err_q;
        wr_en      = 1'b0;
        // First byte of a word lands in the top lane, later bytes go downward.
        lane       = CNT_W'(BYTES_PER_WORD - 1) - byte_cnt_q;
        wr_word    = asm_q;
        wr_word[lane*8 +: 8] = i_byte;

        if (i_load_start) begin
            // Memory contents are kept; only the load bookkeeping restarts.
            state_d    = StLoad;
            byte_cnt_d = '0;
            wr_addr_d  = '0;
            prog_len_d = '0;
            load_err_d = 1'b0;
        end else if (state_q == StLoad && i_byte_valid) begin
            if (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                wr_en      = 1'b1;
                byte_cnt_d = '0;
                wr_addr_d  = wr_addr_q + ADDR_WIDTH'(1);
                prog_len_d = prog_len_q + (ADDR_WIDTH + 1)'(1);
                if (wr_word == END_WORD) begin
                    state_d = StRun;
                end else if (wr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d    = StRun;
                    load_err_d = 1'b1;
                end
            end else begin
                asm_d      = wr_word;
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            wr_addr_q  <= '0;
            prog_len_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            wr_addr_q  <= wr_addr_d;
            prog_len_q <= prog_len_d;
            load_err_q <= load_err_d;
        end
    end

    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr_q] <= wr_word;
        end
    end

    // ---------------------------------------------------------------------
    // Fetch
    // ---------------------------------------------------------------------
    always_comb begin
        word_idx    = i_pc >> BYTE_SHIFT;
        pc_in_range = (word_idx < DATA_WIDTH'(DEPTH));
        rd_idx      = word_idx[ADDR_WIDTH-1:0];
    end

    // Gating on the next state clears the outputs already on the first LOAD
    // cycle, including when a load is restarted from RUN.
    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else if (state_d != StRun) begin
            instr_q <= '0;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else if (state_q == StRun && !i_stall) begin
            pc_q <= i_pc;
            if (pc_in_range) begin
                instr_q <= mem[rd_idx];
                fault_q <= 1'b0;
            end else begin
                instr_q <= '0;
                fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        o_loading     = (state_q == StLoad);
        o_load_done   = (state_q == StRun);
        o_byte_ready  = (state_q == StLoad);
        o_load_err    = load_err_q;
        o_prog_len    = prog_len_q;
        o_instruction = instr_q;
        o_pc          = pc_q;
        o_pc_fault    = fault_q;
    end

endmodule
